// File: rtl/dds_spi_pkg.sv
// Shared definitions for the DDS SPI link: frame width, command codes and
// the responder state encoding.
package dds_spi_pkg;

  localparam int unsigned SPI_BYTE_W    = 8;
  localparam int unsigned SPI_BIT_CNT_W = $clog2(SPI_BYTE_W);

  localparam logic [SPI_BYTE_W-1:0] CMD_WR = 8'h02;
  localparam logic [SPI_BYTE_W-1:0] CMD_RD = 8'h03;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_CMD,
    ST_ADDR_WR,
    ST_ADDR_RD,
    ST_DATA_WR,
    ST_DATA_RD,
    ST_IGNORE
  } spi_state_e;

endpackage

// File: rtl/spi_pin_sync.sv
// Oversampling front end for the SPI pins.
// SCLK and CSN: two synchronizer flops plus one history flop for edge
// detection; MOSI: two synchronizer flops, aligned with the SCLK edge flags.
// Ports:
//   sclk, srstn          system clock, async active-low reset
//   spi_sclk/csn/mosi    raw SPI pins (asynchronous)
//   sclk_rise/sclk_fall  one-cycle SPI clock edge flags
//   csn_rise/csn_fall    one-cycle chip-select edge flags
//   mosi_s               synchronized MOSI
module spi_pin_sync (
  input  logic sclk,
  input  logic srstn,
  input  logic spi_sclk,
  input  logic spi_csn,
  input  logic spi_mosi,
  output logic sclk_rise,
  output logic sclk_fall,
  output logic csn_rise,
  output logic csn_fall,
  output logic mosi_s
);

  logic [2:0] sclk_sync_q, sclk_sync_d;
  logic [2:0] csn_sync_q,  csn_sync_d;
  logic [1:0] mosi_sync_q, mosi_sync_d;

  always_comb begin
    sclk_sync_d = {sclk_sync_q[1:0], spi_sclk};
    csn_sync_d  = {csn_sync_q[1:0],  spi_csn};
    mosi_sync_d = {mosi_sync_q[0],   spi_mosi};
  end

  // CSN history resets low: a pin that is already low when reset releases
  // never produces a fall, so a frame in progress is not picked up midway.
  always_ff @(posedge sclk or negedge srstn) begin
    if (!srstn) begin
      sclk_sync_q <= '0;
      csn_sync_q  <= '0;
      mosi_sync_q <= '0;
    end else begin
      sclk_sync_q <= sclk_sync_d;
      csn_sync_q  <= csn_sync_d;
      mosi_sync_q <= mosi_sync_d;
    end
  end

  assign sclk_rise = sclk_sync_q[1] & ~sclk_sync_q[2];
  assign sclk_fall = ~sclk_sync_q[1] & sclk_sync_q[2];
  assign csn_rise  = csn_sync_q[1] & ~csn_sync_q[2];
  assign csn_fall  = ~csn_sync_q[1] & csn_sync_q[2];
  assign mosi_s    = mosi_sync_q[1];

endmodule

// File: rtl/spi_slave_regif.sv
// SPI mode-0 responder that turns frames into register-bus accesses.
// Frame: command (0x02 write / 0x03 read), start address, data bytes.
// Optional feature macro: SPI_SLAVE_AUTOINC_EN -- when defined the address
// increments after every data byte; otherwise it stays at the start address.
// Ports:
//   sclk, srstn                    system clock, async active-low reset
//   SPI_SCLK, SPI_CSN, SPI_MOSI    SPI inputs (oversampled)
//   SPI_MISO                       SPI output, 0 while CSN is high
//   status_in                      byte returned during the address byte
//   reg_rd_data                    read data, valid the cycle after reg_rd_en
//   reg_addr, reg_wr_data          register bus address / write data
//   reg_wr_en, reg_rd_en           one-cycle access strobes
//   busy                           frame in progress
//   frame_err                      pulse on bad command or aborted byte
module spi_slave_regif
  import dds_spi_pkg::*;
(
  input  logic                  sclk,
  input  logic                  srstn,
  input  logic                  SPI_SCLK,
  input  logic                  SPI_CSN,
  input  logic                  SPI_MOSI,
  output logic                  SPI_MISO,
  input  logic [SPI_BYTE_W-1:0] status_in,
  input  logic [SPI_BYTE_W-1:0] reg_rd_data,
  output logic [SPI_BYTE_W-1:0] reg_addr,
  output logic [SPI_BYTE_W-1:0] reg_wr_data,
  output logic                  reg_wr_en,
  output logic                  reg_rd_en,
  output logic                  busy,
  output logic                  frame_err
);

  logic sclk_rise, sclk_fall, csn_rise, csn_fall, mosi_s;

  spi_pin_sync u_pin_sync (
    .sclk      (sclk),
    .srstn     (srstn),
    .spi_sclk  (SPI_SCLK),
    .spi_csn   (SPI_CSN),
    .spi_mosi  (SPI_MOSI),
    .sclk_rise (sclk_rise),
    .sclk_fall (sclk_fall),
    .csn_rise  (csn_rise),
    .csn_fall  (csn_fall),
    .mosi_s    (mosi_s)
  );

  spi_state_e                state_q, state_d;
  logic [SPI_BIT_CNT_W-1:0]  bit_cnt_q, bit_cnt_d;
  logic [SPI_BYTE_W-1:0]     rx_sh_q, rx_sh_d;
  logic [SPI_BYTE_W-1:0]     tx_sh_q, tx_sh_d;
  logic [SPI_BYTE_W-1:0]     addr_q, addr_d;
  logic [SPI_BYTE_W-1:0]     wr_data_q, wr_data_d;
  logic [SPI_BYTE_W-1:0]     status_q, status_d;
  logic                      miso_q, miso_d;
  logic                      wr_en_q, wr_en_d;
  logic                      rd_en_q, rd_en_d;
  logic                      ld_q, ld_d;
  logic                      err_q, err_d;
  logic [SPI_BYTE_W-1:0]     rx_byte;
  logic                      byte_done;

  always_comb begin
    state_d   = state_q;
    bit_cnt_d = bit_cnt_q;
    rx_sh_d   = rx_sh_q;
    tx_sh_d   = tx_sh_q;
    addr_d    = addr_q;
    wr_data_d = wr_data_q;
    status_d  = status_q;
    miso_d    = miso_q;
    wr_en_d   = 1'b0;
    rd_en_d   = 1'b0;
    err_d     = 1'b0;
    ld_d      = rd_en_q;
    rx_byte   = {rx_sh_q[SPI_BYTE_W-2:0], mosi_s};
    byte_done = 1'b0;

`ifdef SPI_SLAVE_AUTOINC_EN
    // Step the address only after the strobe has been presented.
    if (wr_en_q || ld_q) begin
      addr_d = addr_q + 8'd1;
    end
`endif

    // Read data arrives the cycle after reg_rd_en; byte boundaries are far
    // enough apart that this never coincides with an SCLK fall.
    if (ld_q && (state_q == ST_DATA_RD)) begin
      tx_sh_d = reg_rd_data;
    end

    if (state_q == ST_IDLE) begin
      if (csn_fall) begin
        state_d   = ST_CMD;
        bit_cnt_d = '0;
        rx_sh_d   = '0;
        tx_sh_d   = '0;
        miso_d    = 1'b0;
        status_d  = status_in;
      end
    end else begin
      if (sclk_rise) begin
        rx_sh_d   = rx_byte;
        bit_cnt_d = bit_cnt_q + SPI_BIT_CNT_W'(1);
        if (bit_cnt_q == '1) begin
          byte_done = 1'b1;
          case (state_q)
            ST_CMD: begin
              if (rx_byte == CMD_WR) begin
                state_d = ST_ADDR_WR;
                tx_sh_d = status_q;
              end else if (rx_byte == CMD_RD) begin
                state_d = ST_ADDR_RD;
                tx_sh_d = status_q;
              end else begin
                state_d = ST_IGNORE;
                tx_sh_d = '0;
                err_d   = 1'b1;
              end
            end
            ST_ADDR_WR: begin
              addr_d  = rx_byte;
              state_d = ST_DATA_WR;
            end
            ST_ADDR_RD: begin
              addr_d  = rx_byte;
              rd_en_d = 1'b1;
              state_d = ST_DATA_RD;
            end
            ST_DATA_WR: begin
              wr_data_d = rx_byte;
              wr_en_d   = 1'b1;
            end
            ST_DATA_RD: begin
              rd_en_d = 1'b1;
            end
            default: ;
          endcase
        end
      end

      // MISO carries tx_sh_q[7]; the shifter empties after eight falls and
      // is refilled after the 8th rise of the byte.
      if (sclk_fall) begin
        miso_d  = tx_sh_q[SPI_BYTE_W-1];
        tx_sh_d = {tx_sh_q[SPI_BYTE_W-2:0], 1'b0};
      end

      // A byte completing in the same cycle keeps its strobe.
      if (csn_rise) begin
        if ((bit_cnt_q != '0) && !byte_done) begin
          err_d = 1'b1;
        end
        state_d   = ST_IDLE;
        bit_cnt_d = '0;
        rx_sh_d   = '0;
        tx_sh_d   = '0;
        miso_d    = 1'b0;
      end
    end
  end

  always_ff @(posedge sclk or negedge srstn) begin
    if (!srstn) begin
      state_q   <= ST_IDLE;
      bit_cnt_q <= '0;
      rx_sh_q   <= '0;
      tx_sh_q   <= '0;
      addr_q    <= '0;
      wr_data_q <= '0;
      status_q  <= '0;
      miso_q    <= 1'b0;
      wr_en_q   <= 1'b0;
      rd_en_q   <= 1'b0;
      ld_q      <= 1'b0;
      err_q     <= 1'b0;
    end else begin
      state_q   <= state_d;
      bit_cnt_q <= bit_cnt_d;
      rx_sh_q   <= rx_sh_d;
      tx_sh_q   <= tx_sh_d;
      addr_q    <= addr_d;
      wr_data_q <= wr_data_d;
      status_q  <= status_d;
      miso_q    <= miso_d;
      wr_en_q   <= wr_en_d;
      rd_en_q   <= rd_en_d;
      ld_q      <= ld_d;
      err_q     <= err_d;
    end
  end

  assign SPI_MISO    = miso_q;
  assign reg_addr    = addr_q;
  assign reg_wr_data = wr_data_q;
  assign reg_wr_en   = wr_en_q;
  assign reg_rd_en   = rd_en_q;
  assign busy        = (state_q != ST_IDLE);
  assign frame_err   = err_q;

endmodule
